// File: rtl/pipe_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// Holds the FSM encoding, byte-enable constants and the bus command record.
package pipe_pkg;

   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      D_BUSY  = 2'd1,
      IF_BUSY = 2'd2
   } arb_state_t;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HI_HALF = 4'b1100;
   localparam logic [3:0] BE_LO_HALF = 4'b0011;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mem_cmd_t;

   // Bytes are never misaligned; halfwords need addr[0]=0, words addr[1:0]=0.
   function automatic logic is_misaligned(input logic sb, input logic sh, input logic [1:0] lo);
      return !sb && (sh ? lo[0] : (lo != 2'b00));
   endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Store lane steering: per-byte-lane enable and write data replication
// for byte, halfword and word stores on a big-endian 32-bit bus.
module store_lane_gen
   import pipe_pkg::*;
(
   input  logic                            wr,
   input  logic                            sb,
   input  logic                            sh,
   input  logic [1:0]                      addr_lo,
   input  logic [NUM_LANES*VEC_W-1:0]      wdata,
   output logic [NUM_LANES-1:0]            be,
   output logic [NUM_LANES-1:0][VEC_W-1:0] wdata_lane
);

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      // Lane 3 carries the lowest byte address.
      localparam logic [1:0] LANE_OFS = 2'(NUM_LANES - 1 - i);

      assign be[i] = !wr ? 1'b1 :
                     sb  ? (addr_lo == LANE_OFS) :
                     sh  ? (addr_lo[1] ? BE_LO_HALF[i] : BE_HI_HALF[i]) :
                           1'b1;

      assign wdata_lane[i] = (wr && sb) ? wdata[VEC_W-1:0] :
                             (wr && sh) ? wdata[VEC_W*(i%2) +: VEC_W] :
                                          wdata[VEC_W*i +: VEC_W];
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port.
// Data wins over fetch; the pipeline is frozen until every held request is served.
module unified_mem_arbiter
   import pipe_pkg::*;
#(
   parameter bit MISALIGN_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        d_sb,
   input  logic        d_sh,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        d_misalign,
   output logic        stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   logic       rst_meta, rst_n;
   arb_state_t state, state_nxt;
   mem_cmd_t   cmd, cmd_nxt, d_cmd, if_cmd;
   logic       d_done, if_done;
   logic       d_pend, if_pend, d_mis;
   logic       d_drop, if_drop, d_keep, if_keep;
   logic [3:0]  d_be;
   logic [31:0] d_wdata_lane;

   // Assert asynchronously, release two edges later so the first cycle is quiet.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   store_lane_gen u_lanes (
      .wr         (d_wr),
      .sb         (d_sb),
      .sh         (d_sh),
      .addr_lo    (d_addr[1:0]),
      .wdata      (d_wdata),
      .be         (d_be),
      .wdata_lane (d_wdata_lane)
   );

   assign d_pend  = d_req & ~d_done;
   assign if_pend = if_req & ~if_done;
   assign stall   = d_pend | if_pend;
   assign d_mis   = MISALIGN_CHECK && is_misaligned(d_sb, d_sh, d_addr[1:0]);

   // A request withdrawn while in flight is still completed on the bus, but discarded.
   assign d_keep  = d_req & ~d_drop;
   assign if_keep = if_req & ~if_drop;

   assign d_cmd  = '{addr: d_addr & 32'hFFFF_FFFC, wr: d_wr, wdata: d_wdata_lane, be: d_be};
   assign if_cmd = '{addr: if_addr & 32'hFFFF_FFFC, wr: 1'b0, wdata: 32'h0, be: BE_WORD};

   always_comb begin
      state_nxt = state;
      cmd_nxt   = cmd;
      case (state)
         IDLE: begin
            if (d_pend) begin
               if (!d_mis) begin
                  state_nxt = D_BUSY;
                  cmd_nxt   = d_cmd;
               end
            end else if (if_pend) begin
               state_nxt = IF_BUSY;
               cmd_nxt   = if_cmd;
            end
         end
         D_BUSY: begin
            if (mem_ack) begin
               if (if_pend) begin
                  state_nxt = IF_BUSY;
                  cmd_nxt   = if_cmd;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         IF_BUSY: begin
            if (mem_ack) begin
               if (d_pend && !d_mis) begin
                  state_nxt = D_BUSY;
                  cmd_nxt   = d_cmd;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cmd        <= '0;
         d_done     <= 1'b0;
         if_done    <= 1'b0;
         d_misalign <= 1'b0;
         d_rdata    <= '0;
         if_rdata   <= '0;
         d_drop     <= 1'b0;
         if_drop    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cmd     <= cmd_nxt;
         d_drop  <= (state == D_BUSY) && !mem_ack && (d_drop || !d_req);
         if_drop <= (state == IF_BUSY) && !mem_ack && (if_drop || !if_req);
         if (!stall) begin
            d_done     <= 1'b0;
            if_done    <= 1'b0;
            d_misalign <= 1'b0;
         end else begin
            if (state == IDLE && d_pend && d_mis) begin
               d_done     <= 1'b1;
               d_misalign <= 1'b1;
               d_rdata    <= '0;
            end
            if (state == D_BUSY && mem_ack && d_keep) begin
               d_done  <= 1'b1;
               d_rdata <= cmd.wr ? 32'h0 : mem_rdata;
            end
            if (state == IF_BUSY && mem_ack && if_keep) begin
               if_done  <= 1'b1;
               if_rdata <= mem_rdata;
            end
         end
      end
   end

   assign mem_req   = (state != IDLE);
   assign mem_addr  = cmd.addr;
   assign mem_wr    = cmd.wr;
   assign mem_wdata = cmd.wdata;
   assign mem_be    = cmd.be;
   assign d_valid   = d_done;
   assign if_valid  = if_done;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed and randomized checks of unified_mem_arbiter against a bus memory model.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req, d_req, d_wr, d_sb, d_sh;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [31:0] if_rdata, d_rdata;
   logic        if_valid, d_valid, d_misalign, stall;
   logic        mem_req, mem_wr;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.MISALIGN_CHECK(1'b1)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_sb(d_sb), .d_sh(d_sh), .d_rdata(d_rdata), .d_valid(d_valid),
      .d_misalign(d_misalign), .stall(stall),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory model: acks after a programmed (or random) number of wait cycles.
   logic [31:0] mem [0:255];
   logic [31:0] ref_mem [0:255];
   int          ack_dly = 0;
   bit          rand_dly = 0;
   bit          ack_stray = 0;
   int          cnt = 0;
   bit          busy = 0;
   logic [31:0] hold_addr, hold_wdata;
   logic [4:0]  hold_ctl;

   always @(negedge clk) begin
      if (!mem_req) begin
         mem_ack   = ack_stray;
         mem_rdata = 32'hDEAD_BEEF;
         busy      = 0;
      end else begin
         if (!busy || mem_ack) begin
            busy       = 1;
            cnt        = rand_dly ? int'($urandom_range(0, 20)) : ack_dly;
            hold_addr  = mem_addr;
            hold_wdata = mem_wdata;
            hold_ctl   = {mem_wr, mem_be};
         end else begin
            chk("hold_addr", mem_addr, hold_addr);
            chk("hold_wdata", mem_wdata, hold_wdata);
            chk("hold_ctl", {27'h0, mem_wr, mem_be}, {27'h0, hold_ctl});
         end
         if (cnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr[9:2]];
         end else begin
            mem_ack = 1'b0;
            cnt--;
         end
      end
   end

   int          issues = 0;
   int          bursts = 0;
   bit          mreq_q = 0;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;
   logic [31:0] log_addr [$];

   always @(posedge clk) begin
      if (mem_req && mem_ack) begin
         issues++;
         last_addr  = mem_addr;
         last_wdata = mem_wdata;
         last_be    = mem_be;
         log_addr.push_back(mem_addr);
         if (mem_wr)
            for (int i = 0; i < 4; i++)
               if (mem_be[i]) mem[mem_addr[9:2]][8*i +: 8] = mem_wdata[8*i +: 8];
      end
      if (mem_req && !mreq_q) bursts++;
      mreq_q = mem_req;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag, output int n);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!stall) return;
         n++;
      end
      chk({tag, "_timeout"}, {31'h0, stall}, 32'h0);
   endtask

   task automatic release_all(input string tag);
      tick();
      d_req = 0; if_req = 0; d_wr = 0; d_sb = 0; d_sh = 0;
      @(negedge clk);
      chk({tag, "_dv_clr"}, {31'h0, d_valid}, 32'h0);
      chk({tag, "_iv_clr"}, {31'h0, if_valid}, 32'h0);
      chk({tag, "_mis_clr"}, {31'h0, d_misalign}, 32'h0);
   endtask

   task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] wd,
                           input logic sb, input logic sh,
                           input logic [3:0] e_be, input logic [31:0] e_wd);
      int n, i0;
      tick();
      ack_dly = 0; i0 = issues;
      d_req = 1; d_wr = 1; d_addr = a; d_wdata = wd; d_sb = sb; d_sh = sh;
      wait_idle(tag, n);
      chk({tag, "_lat"}, n, 2);
      chk({tag, "_addr"}, last_addr, a & 32'hFFFF_FFFC);
      chk({tag, "_be"}, {28'h0, last_be}, {28'h0, e_be});
      chk({tag, "_wdata"}, last_wdata, e_wd);
      chk({tag, "_issues"}, issues - i0, 1);
      chk({tag, "_dv"}, {31'h0, d_valid}, 32'h1);
      chk({tag, "_rdata"}, d_rdata, 32'h0);
      release_all(tag);
   endtask

   task automatic do_mis(input string tag, input logic [31:0] a, input logic wr,
                         input logic sb, input logic sh);
      int n, i0, b0;
      tick();
      i0 = issues; b0 = bursts;
      d_req = 1; d_wr = wr; d_addr = a; d_wdata = 32'h7777_7777; d_sb = sb; d_sh = sh;
      wait_idle(tag, n);
      chk({tag, "_lat"}, n, 1);
      chk({tag, "_dv"}, {31'h0, d_valid}, 32'h1);
      chk({tag, "_mis"}, {31'h0, d_misalign}, 32'h1);
      chk({tag, "_rdata"}, d_rdata, 32'h0);
      chk({tag, "_noissue"}, (issues - i0) + (bursts - b0), 0);
      release_all(tag);
   endtask

   function automatic logic [3:0] exp_be(input logic wr, input logic sb, input logic sh, input logic [1:0] lo);
      if (!wr) return 4'b1111;
      if (sb) return 4'b1000 >> lo;
      if (sh) return lo[1] ? 4'b0011 : 4'b1100;
      return 4'b1111;
   endfunction

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, i0, b0, kind, sz, fw, w;
      bit saw_v, do_d, do_f, mis, wr;
      logic [1:0] lo, flo;
      logic [31:0] wd, ewd;
      logic [3:0] be;

      if_req = 0; d_req = 0; d_wr = 0; d_sb = 0; d_sh = 0;
      if_addr = 0; d_addr = 0; d_wdata = 0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
         ref_mem[i] = mem[i];
      end
      mem[16] = 32'h2001_0005;
      mem[17] = 32'hCAFE_F00D;
      mem[18] = 32'h55AA_55AA;
      mem[32] = 32'h1122_3344;
      mem[64] = 32'h0;

      #12;
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mem_ctl", {27'h0, mem_wr, mem_be}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_done", {29'h0, d_valid, if_valid, d_misalign}, 32'h0);
      chk("rst_rdata", d_rdata | if_rdata, 32'h0);
      #5 reset = 1;
      repeat (3) tick();

      // Fetch only, ack on the third bus cycle
      ack_dly = 2; i0 = issues; b0 = bursts;
      tick();
      if_req = 1; if_addr = 32'h40;
      wait_idle("fetch", n);
      chk("fetch_stall", n, 4);
      chk("fetch_iv", {31'h0, if_valid}, 32'h1);
      chk("fetch_rdata", if_rdata, 32'h2001_0005);
      chk("fetch_issues", issues - i0, 1);
      chk("fetch_bursts", bursts - b0, 1);
      release_all("fetch");

      // Stray acks while idle are ignored
      tick();
      ack_stray = 1;
      repeat (3) tick();
      ack_stray = 0;
      @(negedge clk);
      chk("stray_valid", {30'h0, d_valid, if_valid}, 32'h0);
      chk("stray_rdata", if_rdata, 32'h2001_0005);

      // Load and fetch together: data first, one continuous burst
      ack_dly = 1; i0 = issues; b0 = bursts; log_addr.delete();
      tick();
      d_req = 1; d_wr = 0; d_addr = 32'h80; if_req = 1; if_addr = 32'h44;
      wait_idle("both", n);
      chk("both_stall", n, 5);
      chk("both_issues", issues - i0, 2);
      chk("both_bursts", bursts - b0, 1);
      chk("both_first", log_addr[0], 32'h80);
      chk("both_second", log_addr[1], 32'h44);
      chk("both_valid", {30'h0, d_valid, if_valid}, 32'h3);
      chk("both_drdata", d_rdata, 32'h1122_3344);
      chk("both_irdata", if_rdata, 32'hCAFE_F00D);
      release_all("both");

      do_mis("mis_ld_word", 32'h81, 1'b0, 1'b0, 1'b0);

      do_store("st_b3", 32'h103, 32'h0000_00AB, 1'b1, 1'b0, 4'b0001, 32'hABAB_ABAB);
      do_store("st_b0", 32'h100, 32'h1234_56CD, 1'b1, 1'b0, 4'b1000, 32'hCDCD_CDCD);
      do_store("st_h2", 32'h102, 32'h1234_BEEF, 1'b0, 1'b1, 4'b0011, 32'hBEEF_BEEF);
      do_store("st_h0", 32'h100, 32'h0000_5678, 1'b0, 1'b1, 4'b1100, 32'h5678_5678);
      do_store("st_w", 32'h104, 32'hDEAD_C0DE, 1'b0, 1'b0, 4'b1111, 32'hDEAD_C0DE);
      chk("mem_0x100", mem[64], 32'h5678_BEEF);

      do_mis("mis_st_word", 32'h102, 1'b1, 1'b0, 1'b0);
      do_mis("mis_st_half", 32'h101, 1'b1, 1'b0, 1'b1);

      // Data request withdrawn mid-access: completes on the bus, result dropped
      ack_dly = 3; i0 = issues; saw_v = 0;
      tick();
      d_req = 1; d_wr = 0; d_addr = 32'h80;
      tick();
      d_req = 0;
      for (int k = 0; k < 20 && mem_req; k++) begin
         @(negedge clk);
         saw_v |= d_valid;
      end
      chk("drop_idle", {31'h0, mem_req}, 32'h0);
      chk("drop_valid", {31'h0, saw_v}, 32'h0);
      chk("drop_issues", issues - i0, 1);
      chk("drop_rdata", d_rdata, 32'h0);

      // Reset while the bus is waiting, then a clean re-issue
      ack_dly = 10;
      tick();
      if_req = 1; if_addr = 32'h48;
      repeat (3) @(negedge clk);
      chk("rstw_req_pre", {31'h0, mem_req}, 32'h1);
      #2 reset = 0;
      #1;
      chk("rstw_req", {31'h0, mem_req}, 32'h0);
      chk("rstw_ctl", {27'h0, mem_wr, mem_be}, 32'h0);
      chk("rstw_addr", mem_addr, 32'h0);
      @(posedge clk);
      #2 reset = 1;
      ack_dly = 1; i0 = issues; b0 = bursts;
      @(posedge clk);
      @(negedge clk);
      chk("rstw_quiet", {31'h0, mem_req}, 32'h0);
      wait_idle("rstw", n);
      chk("rstw_lat", n, 3);
      chk("rstw_rdata", if_rdata, 32'h55AA_55AA);
      chk("rstw_issues", issues - i0, 1);
      chk("rstw_bursts", bursts - b0, 1);
      release_all("rstw");

      // Randomized mixed traffic against a reference memory
      rand_dly = 1;
      for (int t = 0; t < 1000; t++) begin
         kind = $urandom_range(0, 2);
         do_d = (kind != 0);
         do_f = (kind != 1);
         wr   = $urandom_range(0, 1);
         sz   = wr ? $urandom_range(0, 2) : 0;
         w    = $urandom_range(0, 15);
         fw   = $urandom_range(0, 15);
         lo   = 2'($urandom_range(0, 3));
         flo  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 0) lo = 2'b00;
            else if (sz == 1) lo[0] = 1'b0;
         end
         wd  = $urandom;
         mis = (sz == 0 && lo != 2'b00) || (sz == 1 && lo[0]);
         tick();
         i0 = issues;
         d_req = do_d; d_wr = wr; d_addr = 32'h200 + w * 4 + lo; d_wdata = wd;
         d_sb = (sz == 2); d_sh = (sz == 1);
         if_req = do_f; if_addr = 32'h200 + fw * 4 + flo;
         wait_idle("rnd", n);
         if (do_d) begin
            chk("rnd_dv", {31'h0, d_valid}, 32'h1);
            chk("rnd_mis", {31'h0, d_misalign}, {31'h0, mis});
            chk("rnd_drdata", d_rdata, (wr || mis) ? 32'h0 : ref_mem[128 + w]);
            if (wr && !mis) begin
               be  = exp_be(1'b1, sz == 2, sz == 1, lo);
               ewd = (sz == 2) ? {4{wd[7:0]}} : (sz == 1) ? {2{wd[15:0]}} : wd;
               for (int i = 0; i < 4; i++)
                  if (be[i]) ref_mem[128 + w][8*i +: 8] = ewd[8*i +: 8];
            end
         end
         if (do_f) begin
            chk("rnd_iv", {31'h0, if_valid}, 32'h1);
            chk("rnd_irdata", if_rdata, ref_mem[128 + fw]);
         end
         chk("rnd_issues", issues - i0, int'(do_f) + int'(do_d && !mis));
         release_all("rnd");
      end
      for (int i = 0; i < 16; i++)
         chk("rnd_mem", mem[128 + i], ref_mem[128 + i]);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter: MISALIGN_CHECK, default 1, enables alignment checking of data accesses.
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  fetch request; if_addr  in  32  fetch byte address.
REQ-005 if_rdata  out  32  fetched instruction; if_valid  out  1  fetch complete, level.
REQ-006 d_req  in  1  data request; d_wr  in  1  store (1) or load (0); d_addr  in  32; d_wdata  in  32.
REQ-007 d_sb, d_sh  in  1 each  byte and halfword store size; neither set means word.
REQ-008 d_rdata  out  32  load data; d_valid  out  1  data complete, level; d_misalign  out  1  misaligned-access flag, level.
REQ-009 stall  out  1  pipeline freeze, gates the pipeline register and PC enables.
REQ-010 mem_req  out  1; mem_addr  out  32; mem_wr  out  1; mem_wdata  out  32; mem_be  out  4.
REQ-011 mem_ack  in  1  access done this cycle; mem_rdata  in  32  valid when mem_ack=1.

Function
REQ-012 FSM states SHALL be IDLE, D_BUSY and IF_BUSY.
REQ-013 IDLE: a pending data request (d_req & ~d_done) -> D_BUSY; else a pending fetch (if_req & ~if_done) -> IF_BUSY; data SHALL win over fetch.
REQ-014 In either BUSY state, mem_req=1, and mem_addr/mem_wr/mem_wdata/mem_be SHALL be registered and held stable until mem_ack.
REQ-015 BUSY & ~mem_ack: remain in state, for any wait length.
REQ-016 D_BUSY & mem_ack: set d_done and capture mem_rdata into d_rdata; stores SHALL capture 0. Next state is IF_BUSY if a fetch is pending, else IDLE.
REQ-017 IF_BUSY & mem_ack: set if_done and capture mem_rdata into if_rdata. Next state is D_BUSY if a data request is pending, else IDLE.
REQ-018 d_valid=d_done; if_valid=if_done; rdata outputs SHALL stay stable while done is set.
REQ-019 stall SHALL be combinational: (d_req & ~d_done) | (if_req & ~if_done).
REQ-020 Both done flags SHALL clear on any edge where stall=0, so a held request is never re-issued while the other is still outstanding.
REQ-021 Minimum latency: request seen in IDLE at edge N -> mem_req from N; ack in the same cycle -> valid from N+1.
REQ-022 Loads: mem_be=1111 and mem_wr=0.
REQ-023 Byte stores (big-endian): mem_be one-hot at bit 3-addr[1:0]; mem_wdata = the low byte of d_wdata replicated four times.
REQ-024 Halfword stores: mem_be=1100 if addr[1]=0, else 0011; mem_wdata = the low halfword replicated twice.
REQ-025 Word stores: mem_be=1111.
REQ-026 mem_addr SHALL be the request address with bits [1:0] forced to 0.
REQ-027 Misaligned access (MISALIGN_CHECK=1): a halfword with addr[0]=1, or a word with addr[1:0]!=0, SHALL NOT be issued.
REQ-028 On a misaligned access: d_done and d_misalign are set directly from IDLE, d_rdata=0; d_misalign SHALL clear with d_done.
REQ-029 A fetch with if_addr[1:0]!=0 SHALL be issued as aligned; no flag.
REQ-030 Request dropped mid-access: the access SHALL complete, with the result discarded and the done flag not set.
REQ-031 mem_ack outside a BUSY state SHALL be ignored.

Reset
REQ-032 Reset low SHALL immediately force: IDLE, mem_req=0, mem_wr=0, mem_be=0, mem_addr=0, mem_wdata=0, both done flags 0, both rdata 0, d_misalign 0.
REQ-033 Reset mid-access SHALL abandon the access; the memory model SHALL tolerate mem_req dropping.
REQ-034 Reset release SHALL be synchronized to clk; there SHALL be no activity in the first cycle after release.

Structure
REQ-035 State encodings and byte-enable constants SHALL live in the shared package pipe_pkg.
REQ-036 Lane steering (be and wdata replication) SHALL be one sub-module, store_lane_gen.

Verification
REQ-037 Fetch only: if_addr=0x40, 3-cycle ack, rdata=0x20010005 -> stall high 4 cycles, if_valid then if_rdata=0x20010005, a single mem_req burst.
REQ-038 Fetch and load together: data access issued first, then the fetch without mem_req dropping. Stall falls only after both complete; each issued exactly once.
REQ-039 Byte store: d_addr=0x103, d_wdata=0xAB -> mem_addr=0x100, mem_be=0001, mem_wdata=0xABABABAB.
REQ-040 Halfword store at 0x102 -> be=0011; word store at 0x102 -> no mem_req, d_misalign=1 and d_valid=1 for one cycle.
REQ-041 Reset pulled low with mem_req high mid-wait -> mem_req=0 in the same cycle; after release, if_req is re-issued cleanly.
REQ-042 Random ack delays 0-20 over 1000 mixed requests -> no duplicate issue, no lost request, rdata matches the memory model.
